// File: rtl/bht_update_scheduler_pkg.sv
// Shared types and helpers for the branch history table update path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bp_pkg;

    // Scheduler control states: clear sweep, wait for work, read-modify-write.
    typedef enum logic [1:0] {
        SWEEP  = 2'd0,
        IDLE   = 2'd1,
        UPDATE = 2'd2
    } bht_state_t;

    localparam int BP_IDX_W = 6;
    localparam int BP_PC_W  = 8;

    // Two-bit saturating counter encodings.
    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    // Next counter value: step toward the resolved outcome, saturating at the ends.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_update_scheduler_if.sv
// Resolved-branch update handshake from decode into the BHT update scheduler.
// Latency: n/a (wiring only).
// Backpressure: valid/ready; an update transfers on a cycle where both are high.
interface bht_update_scheduler_if import bp_pkg::*; #(
    parameter int PC_W = BP_PC_W
);
    logic            upd_valid;
    logic            upd_ready;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;

    // Producer side (decode).
    modport master (output upd_valid, output upd_pc, output upd_taken, input upd_ready);
    // Consumer side (scheduler).
    modport slave  (input upd_valid, input upd_pc, input upd_taken, output upd_ready);

endinterface

// File: rtl/bht_upd_fifo.sv
// Small circular FIFO holding pending BHT updates, with occupancy count.
// Latency: push visible at the head one cycle later; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full.
module bht_upd_fifo import bp_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bht_update_scheduler.sv
// Clears the BHT after reset, then applies queued branch outcomes as 2-bit counter read-modify-writes.
// Latency: one update per 2 cycles (read cycle, then write cycle); first read the cycle after enqueue at the earliest.
// Backpressure: upd_ready low during the clear sweep or when the queue is full; reads yield to lookup_active. Optional BHT_UPD_STATS_EN adds upd_count.
module bht_update_scheduler import bp_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int IDX_W = BP_IDX_W,
    parameter int PC_W  = BP_PC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    bht_update_scheduler_if.slave   upd,
    input  logic                    lookup_active,
    output logic                    bht_re,
    output logic [IDX_W-1:0]        bht_raddr,
    input  logic [1:0]              bht_rdata,
    output logic                    bht_we,
    output logic [IDX_W-1:0]        bht_waddr,
    output logic [1:0]              bht_wdata,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  pending
`ifdef BHT_UPD_STATS_EN
    ,
    output logic [15:0]             upd_count
`endif
);
    typedef struct packed {
        logic             taken;
        logic [IDX_W-1:0] idx;
    } upd_entry_t;

    bht_state_t       state;
    bht_state_t       state_nxt;
    logic [IDX_W-1:0] sweep_idx;
    upd_entry_t       push_ent;
    upd_entry_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    // Only the low PC bits index the table; the rest is deliberately dropped.
    generate
        if (PC_W > IDX_W) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^upd.upd_pc[PC_W-1:IDX_W];
        end
    endgenerate

    assign push_ent.idx   = upd.upd_pc[IDX_W-1:0];
    assign push_ent.taken = upd.upd_taken;
    assign upd.upd_ready  = (state != SWEEP) && !fifo_full;
    assign fifo_push      = upd.upd_valid && upd.upd_ready;
    assign busy           = (state == SWEEP);

    bht_upd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(upd_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_ent),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SWEEP;
        else        state <= state_nxt;
    end

    // Sweep address advances once per clear write and restarts from 0 on every reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              sweep_idx <= '0;
        else if (state == SWEEP) sweep_idx <= sweep_idx + IDX_W'(1);
    end

    // Next state and BHT port control.
    always_comb begin
        state_nxt = state;
        bht_re    = 1'b0;
        bht_raddr = head.idx;
        bht_we    = 1'b0;
        bht_waddr = sweep_idx;
        bht_wdata = CTR_SNT;
        fifo_pop  = 1'b0;
        case (state)
            SWEEP: begin
                // Held off while reset is asserted so the table sees no write until the first edge after release.
                bht_we    = reset;
                bht_waddr = sweep_idx;
                bht_wdata = CTR_SNT;
                if (sweep_idx == '1) state_nxt = IDLE;
            end
            IDLE: begin
                // Fetch owns the read port whenever it asks; updates simply wait.
                if (!fifo_empty && !lookup_active) begin
                    bht_re    = 1'b1;
                    bht_raddr = head.idx;
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                // Read data arrives now; head is unchanged since the read was issued.
                bht_we    = 1'b1;
                bht_waddr = head.idx;
                bht_wdata = ctr_next(bht_rdata, head.taken);
                fifo_pop  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = SWEEP;
        endcase
    end

`ifdef BHT_UPD_STATS_EN
    // Count completed counter updates, sticking at the maximum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) upd_count <= '0;
        else if (state == UPDATE && upd_count != 16'hFFFF) upd_count <= upd_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bht_update_scheduler.sv
module tb_bht_update_scheduler;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDX_W = 6;
    localparam int PC_W  = 8;
    localparam int N     = 1 << IDX_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             lookup_active = 1'b0;
    logic             bht_re;
    logic [IDX_W-1:0] bht_raddr;
    logic [1:0]       bht_rdata = 2'b00;
    logic             bht_we;
    logic [IDX_W-1:0] bht_waddr;
    logic [1:0]       bht_wdata;
    logic             busy;
    logic [CW-1:0]    pending;
`ifdef BHT_UPD_STATS_EN
    logic [15:0]      upd_count;
`endif

    always #5 clk = ~clk;

    bht_update_scheduler_if #(.PC_W(PC_W)) upd_if ();

    bht_update_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PC_W(PC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .upd           (upd_if),
        .lookup_active (lookup_active),
        .bht_re        (bht_re),
        .bht_raddr     (bht_raddr),
        .bht_rdata     (bht_rdata),
        .bht_we        (bht_we),
        .bht_waddr     (bht_waddr),
        .bht_wdata     (bht_wdata),
        .busy          (busy),
        .pending       (pending)
`ifdef BHT_UPD_STATS_EN
        ,
        .upd_count     (upd_count)
`endif
    );

    // Synchronous BHT RAM plus write/protocol monitor.
    typedef struct { int addr; int data; } wr_t;
    typedef struct { int idx; int taken; } upd_t;

    logic [1:0] mem [N];
    wr_t        sweep_log[$];
    wr_t        upd_log[$];
    int         n_wr = 0;
    int         viol = 0;

    always @(posedge clk) begin
        if (bht_we) mem[bht_waddr] <= bht_wdata;
        if (bht_re) bht_rdata <= mem[bht_raddr];
        if (bht_we && busy)  sweep_log.push_back('{int'(bht_waddr), int'(bht_wdata)});
        if (bht_we && !busy) begin
            upd_log.push_back('{int'(bht_waddr), int'(bht_wdata)});
            n_wr++;
        end
        if (bht_re && (lookup_active || busy || bht_we)) viol++;
        if (!reset && (bht_we || bht_re)) viol++;
    end

    // Reference model state: expected queue of accepted updates and the table contents they imply.
    upd_t exp_q[$];
    int   ref_mem[N];
    int   upd_rd = 0;
    int   sweep_base = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic int sat_model(input int v, input int taken);
        if (taken != 0) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < N; i++) ref_mem[i] = 0;
        upd_rd     = upd_log.size();
        sweep_base = sweep_log.size();
    endtask

    task automatic push(input int pc, input int taken, input int max_wait);
        bit ok;
        ok = 1'b0;
        upd_if.upd_valid = 1'b1;
        upd_if.upd_pc    = PC_W'(pc);
        upd_if.upd_taken = taken[0];
        for (int k = 0; k < max_wait && !ok; k++) begin
            if (upd_if.upd_ready === 1'b1) begin
                ok = 1'b1;
                exp_q.push_back('{pc % N, taken});
            end
            tick();
        end
        upd_if.upd_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_accept: pc=%0d not accepted in %0d cycles, required accepted", pc, max_wait);
        end
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        lookup_active = 1'b0;
        while (pending !== CW'(0) && cnt < 100) begin
            tick();
            cnt++;
        end
        tick();
        n_checks++;
        if (cnt >= 100) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d after %0d cycles, required 0", pending, cnt);
        end
    endtask

    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        int bad;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_pc    = '0;
        upd_if.upd_taken = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || pending !== CW'(0) || upd_if.upd_ready !== 1'b0 || bht_re !== 1'b0 || bht_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b pending=%0d ready=%b re=%b we=%b, required 1 0 0 0 0",
                     busy, pending, upd_if.upd_ready, bht_re, bht_we);
        end
        model_reset();
        reset = 1'b1;
        wait_sweep(cnt);
        n_checks++;
        if (cnt != N) begin
            n_fail++;
            $display("FAIL sweep_cycles: busy for %0d cycles, required %0d", cnt, N);
        end
        n_checks++;
        if (sweep_log.size() - sweep_base != N) begin
            n_fail++;
            $display("FAIL sweep_count: %0d clear writes, required %0d", sweep_log.size() - sweep_base, N);
        end
        bad = 0;
        for (int i = 0; i < N && sweep_base + i < sweep_log.size(); i++)
            if (sweep_log[sweep_base + i].addr != i || sweep_log[sweep_base + i].data != 0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sweep_order: %0d clear writes out of order or nonzero, required 0", bad);
        end
        n_checks++;
        if (upd_if.upd_ready !== 1'b1 || pending !== CW'(0)) begin
            n_fail++;
            $display("FAIL post_sweep: ready=%b pending=%0d, required 1 0", upd_if.upd_ready, pending);
        end
    endtask

    task automatic test_saturate();
        lookup_active = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h05, 1, 20);
        drain();
        while (upd_rd < upd_log.size()) begin
            wr_t w;
            upd_t e;
            int v;
            w = upd_log[upd_rd];
            upd_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sat_write: stray write addr=%0d data=%0d, required none", w.addr, w.data);
            end else begin
                e = exp_q.pop_front();
                v = sat_model(ref_mem[e.idx], e.taken);
                ref_mem[e.idx] = v;
                if (w.addr != e.idx || w.data != v) begin
                    n_fail++;
                    $display("FAIL sat_write: addr=%0d data=%0d, required addr=%0d data=%0d", w.addr, w.data, e.idx, v);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sat_missing: %0d updates unwritten, required 0", exp_q.size());
        end
        n_checks++;
        if (mem[5] !== 2'b11) begin
            n_fail++;
            $display("FAIL sat_final: bht[5]=%b, required 11", mem[5]);
        end
    endtask

    task automatic test_full();
        int cnt;
        lookup_active = 1'b1;
        for (int i = 0; i < 4; i++) push(i * 9 + 3, int'($urandom_range(0, 1)), 1);
        n_checks++;
        if (pending !== CW'(4) || upd_if.upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: pending=%0d ready=%b, required 4 0", pending, upd_if.upd_ready);
        end
        upd_if.upd_valid = 1'b1;
        upd_if.upd_pc    = 8'h2A;
        upd_if.upd_taken = 1'b1;
        tick();
        upd_if.upd_valid = 1'b0;
        n_checks++;
        if (pending !== CW'(4)) begin
            n_fail++;
            $display("FAIL full_fifth: pending=%0d, required 4", pending);
        end
        lookup_active = 1'b0;
        cnt = 0;
        while (pending !== CW'(0) && cnt < 50) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL full_drain: drained in %0d cycles, required 8", cnt);
        end
        tick();
        while (upd_rd < upd_log.size()) begin
            wr_t w;
            upd_t e;
            int v;
            w = upd_log[upd_rd];
            upd_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL full_write: stray write addr=%0d data=%0d, required none", w.addr, w.data);
            end else begin
                e = exp_q.pop_front();
                v = sat_model(ref_mem[e.idx], e.taken);
                ref_mem[e.idx] = v;
                if (w.addr != e.idx || w.data != v) begin
                    n_fail++;
                    $display("FAIL full_write: addr=%0d data=%0d, required addr=%0d data=%0d", w.addr, w.data, e.idx, v);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_missing: %0d updates unwritten, required 0", exp_q.size());
        end
    endtask

    task automatic test_lookup_block();
        lookup_active = 1'b1;
        push(8'h17, 0, 5);
        n_checks++;
        if (pending !== CW'(1)) begin
            n_fail++;
            $display("FAIL lookup_pending: pending=%0d, required 1", pending);
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bht_re !== 1'b0) begin
                n_fail++;
                $display("FAIL lookup_hold: bht_re=%b at cycle %0d, required 0", bht_re, i);
            end
            tick();
        end
        lookup_active = 1'b0;
        #1;
        n_checks++;
        if (bht_re !== 1'b1 || bht_raddr !== IDX_W'(8'h17)) begin
            n_fail++;
            $display("FAIL lookup_release: re=%b raddr=%0d, required 1 %0d", bht_re, bht_raddr, 8'h17 % N);
        end
        drain();
        while (upd_rd < upd_log.size()) begin
            wr_t w;
            upd_t e;
            int v;
            w = upd_log[upd_rd];
            upd_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL lookup_write: stray write addr=%0d data=%0d, required none", w.addr, w.data);
            end else begin
                e = exp_q.pop_front();
                v = sat_model(ref_mem[e.idx], e.taken);
                ref_mem[e.idx] = v;
                if (w.addr != e.idx || w.data != v) begin
                    n_fail++;
                    $display("FAIL lookup_write: addr=%0d data=%0d, required addr=%0d data=%0d", w.addr, w.data, e.idx, v);
                end
            end
        end
    endtask

    task automatic test_random();
        int n_push;
        int wr_base;
        int occ;
        n_push  = 0;
        wr_base = n_wr;
        for (int c = 0; c < 300; c++) begin
            int pc;
            int tk;
            pc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            tk = int'($urandom_range(0, 1));
            upd_if.upd_valid = ($urandom_range(0, 2) != 0);
            upd_if.upd_pc    = PC_W'(pc);
            upd_if.upd_taken = tk[0];
            lookup_active    = ($urandom_range(0, 3) == 0);
            #1;
            occ = n_push - (n_wr - wr_base);
            n_checks++;
            if (upd_if.upd_ready !== (occ < DEPTH)) begin
                n_fail++;
                $display("FAIL rand_ready: ready=%b occupancy=%0d, required %b", upd_if.upd_ready, occ, occ < DEPTH);
            end
            if (upd_if.upd_valid && upd_if.upd_ready) begin
                exp_q.push_back('{pc % N, tk});
                n_push++;
            end
            @(posedge clk);
            #1;
            occ = n_push - (n_wr - wr_base);
            n_checks++;
            if (pending !== CW'(occ)) begin
                n_fail++;
                $display("FAIL rand_pending: pending=%0d, required %0d", pending, occ);
            end
        end
        upd_if.upd_valid = 1'b0;
        drain();
        while (upd_rd < upd_log.size()) begin
            wr_t w;
            upd_t e;
            int v;
            w = upd_log[upd_rd];
            upd_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rand_write: stray write addr=%0d data=%0d, required none", w.addr, w.data);
            end else begin
                e = exp_q.pop_front();
                v = sat_model(ref_mem[e.idx], e.taken);
                ref_mem[e.idx] = v;
                if (w.addr != e.idx || w.data != v) begin
                    n_fail++;
                    $display("FAIL rand_write: addr=%0d data=%0d, required addr=%0d data=%0d", w.addr, w.data, e.idx, v);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_missing: %0d updates unwritten, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int bad;
        lookup_active = 1'b1;
        for (int i = 0; i < 3; i++) push(i + 40, 1, 5);
        lookup_active = 1'b0;
        tick();
        n_checks++;
        if (bht_we !== 1'b1 || busy !== 1'b0 || pending !== CW'(3)) begin
            n_fail++;
            $display("FAIL mid_setup: we=%b busy=%b pending=%0d, required 1 0 3", bht_we, busy, pending);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (pending !== CW'(0) || busy !== 1'b1 || bht_we !== 1'b0 || upd_if.upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: pending=%0d busy=%b we=%b ready=%b, required 0 1 0 0",
                     pending, busy, bht_we, upd_if.upd_ready);
        end
        tick();
        tick();
        model_reset();
        reset = 1'b1;
        wait_sweep(cnt);
        n_checks++;
        if (cnt != N || sweep_log.size() - sweep_base != N) begin
            n_fail++;
            $display("FAIL mid_sweep: %0d cycles %0d writes, required %0d %0d", cnt, sweep_log.size() - sweep_base, N, N);
        end
        bad = 0;
        for (int i = 0; i < N && sweep_base + i < sweep_log.size(); i++)
            if (sweep_log[sweep_base + i].addr != i || sweep_log[sweep_base + i].data != 0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_sweep_order: %0d bad clear writes, required 0", bad);
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (upd_log.size() != upd_rd || pending !== CW'(0)) begin
            n_fail++;
            $display("FAIL mid_stale: %0d stale writes pending=%0d, required 0 0", upd_log.size() - upd_rd, pending);
        end
    endtask

`ifdef BHT_UPD_STATS_EN
    task automatic test_stats();
        int cnt;
        n_checks++;
        if (upd_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_start: upd_count=%0d, required 0", upd_count);
        end
        for (int i = 0; i < 5; i++) push(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 20);
        drain();
        n_checks++;
        if (upd_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stats_count: upd_count=%0d, required 5", upd_count);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (upd_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset: upd_count=%0d, required 0", upd_count);
        end
        tick();
        model_reset();
        reset = 1'b1;
        wait_sweep(cnt);
    endtask
`endif

    task automatic test_protocol();
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL protocol: %0d illegal read/write cycles, required 0", viol);
        end
    endtask

    initial begin
        upd_if.upd_valid = 1'b0;
        upd_if.upd_pc    = '0;
        upd_if.upd_taken = 1'b0;
        test_reset();
        test_saturate();
        test_full();
        test_lookup_block();
        test_random();
        test_reset_mid();
`ifdef BHT_UPD_STATS_EN
        test_stats();
`endif
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
